// File: rtl/vdu_console.sv
// vdu_console: character-stream writer for the vdu text buffer.
//
// Accepts bytes over a valid/ready handshake and writes them to a
// COLS x ROWS character buffer starting at BASE_ADDR. It uses one RAM
// write port. CR, LF, BS and FF are interpreted as control codes. All
// other codes are printed at the cursor.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_data         byte to process, sampled on acceptance
//   i_valid        i_data valid
//   o_ready        byte accepted on an edge where i_valid && o_ready
//   o_write_en     character RAM write strobe, one cycle per cell
//   o_write_addr   BASE_ADDR + row*COLS + col, modulo 2^16
//   o_write_data   character code to write
//   o_col, o_row   cursor position
//   o_busy         line or screen clear in progress
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | ready for a byte; no write this cycle
// S_PUT      | single write at the cursor (printable char or BS blank)
// S_CLR_LINE | blanking columns 0..COLS-1 of the cursor row
// S_CLR_ALL  | blanking the whole buffer in ascending address order

module vdu_console #(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 25,
    parameter int unsigned BASE_ADDR  = 0,
    parameter logic [7:0]  BLANK_CHAR = 8'h20,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_write_en,
    output logic [15:0] o_write_addr,
    output logic [7:0]  o_write_data,
    output logic [15:0] o_col,
    output logic [15:0] o_row,
    output logic        o_busy
);

    localparam int unsigned TOTAL = COLS * ROWS;
    localparam int          CW    = $clog2(TOTAL + 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUT,
        S_CLR_LINE,
        S_CLR_ALL
    } state_t;

    localparam state_t RESET_STATE = INIT_CLEAR ? S_CLR_ALL : S_IDLE;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           put_bs_q, put_bs_d;
    logic [15:0]    col_d, row_d, row_inc;
    logic           ready_d, we_d, busy_d;
    logic [15:0]    addr_d;
    logic [7:0]     data_d;

    function automatic logic [15:0] cell_addr(input logic [31:0] row, input logic [31:0] col);
        logic [31:0] a;
        a = BASE_ADDR + row * COLS + col;
        return a[15:0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            put_bs_q     <= 1'b0;
            o_col        <= '0;
            o_row        <= '0;
            o_ready      <= 1'b0;
            o_write_en   <= 1'b0;
            o_write_addr <= '0;
            o_write_data <= '0;
            o_busy       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            put_bs_q     <= put_bs_d;
            o_col        <= col_d;
            o_row        <= row_d;
            o_ready      <= ready_d;
            o_write_en   <= we_d;
            o_write_addr <= addr_d;
            o_write_data <= data_d;
            o_busy       <= busy_d;
        end
    end

    // Outputs are registered together with the state. The values computed
    // here describe the cycle that follows the edge. A write issued on
    // entry to a state is therefore visible during that state's first cycle.
    // cnt holds the index of the next cell to blank. Entry into a clear
    // writes cell 0 directly and sets cnt to 1. The clear ends on the edge
    // where cnt has reached its limit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        put_bs_d = put_bs_q;
        col_d    = o_col;
        row_d    = o_row;
        ready_d  = 1'b0;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        addr_d   = o_write_addr;
        data_d   = o_write_data;
        row_inc  = (o_row == 16'(ROWS - 1)) ? 16'd0 : o_row + 16'd1;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (i_valid && o_ready) begin
                    case (i_data)
                        CH_CR: begin
                            col_d = '0;
                        end
                        CH_LF: begin
                            col_d   = '0;
                            row_d   = row_inc;
                            state_d = S_CLR_LINE;
                            cnt_d   = CW'(1);
                            we_d    = 1'b1;
                            addr_d  = cell_addr(32'(row_inc), 32'd0);
                            data_d  = BLANK_CHAR;
                            ready_d = 1'b0;
                            busy_d  = 1'b1;
                        end
                        CH_BS: begin
                            if (o_col != 16'd0) begin
                                col_d    = o_col - 16'd1;
                                state_d  = S_PUT;
                                put_bs_d = 1'b1;
                                we_d     = 1'b1;
                                addr_d   = cell_addr(32'(o_row), 32'(o_col - 16'd1));
                                data_d   = BLANK_CHAR;
                                ready_d  = 1'b0;
                            end
                        end
                        CH_FF: begin
                            state_d = S_CLR_ALL;
                            cnt_d   = CW'(1);
                            we_d    = 1'b1;
                            addr_d  = cell_addr(32'd0, 32'd0);
                            data_d  = BLANK_CHAR;
                            ready_d = 1'b0;
                            busy_d  = 1'b1;
                        end
                        default: begin
                            state_d  = S_PUT;
                            put_bs_d = 1'b0;
                            we_d     = 1'b1;
                            addr_d   = cell_addr(32'(o_row), 32'(o_col));
                            data_d   = i_data;
                            ready_d  = 1'b0;
                        end
                    endcase
                end
            end

            S_PUT: begin
                if (put_bs_q) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (o_col < 16'(COLS - 1)) begin
                    col_d   = o_col + 16'd1;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    // Last column: move to the next row and blank it
                    // before any more text can land there.
                    col_d   = '0;
                    row_d   = row_inc;
                    state_d = S_CLR_LINE;
                    cnt_d   = CW'(1);
                    we_d    = 1'b1;
                    addr_d  = cell_addr(32'(row_inc), 32'd0);
                    data_d  = BLANK_CHAR;
                    busy_d  = 1'b1;
                end
            end

            S_CLR_LINE: begin
                if (cnt_q < CW'(COLS)) begin
                    cnt_d  = cnt_q + CW'(1);
                    we_d   = 1'b1;
                    addr_d = cell_addr(32'(o_row), 32'(cnt_q));
                    data_d = BLANK_CHAR;
                    busy_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end

            S_CLR_ALL: begin
                if (cnt_q < CW'(TOTAL)) begin
                    cnt_d  = cnt_q + CW'(1);
                    we_d   = 1'b1;
                    addr_d = cell_addr(32'd0, 32'(cnt_q));
                    data_d = BLANK_CHAR;
                    busy_d = 1'b1;
                end else begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
